// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: arbiter FSM state encoding,
// the data byte width and the default baud divisor.
package uart_pkg;

    localparam int BYTE_W           = 8;
    localparam int BAUD_DIV_DEFAULT = 434;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud tick generator: tick is high for one clk cycle whenever
// the counter sits at BAUD_DIV-1, after which the counter wraps to zero.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is always written with <= so every register
    // samples its inputs from the same clock edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
// Optional frame counter output frames_sent is built when UART_TX_ARB_CNT_EN is defined.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_en,
    output logic                        uart_start,
    output logic [BYTE_W-1:0]           uart_data,
    input  logic                        uart_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
`ifdef UART_TX_ARB_CNT_EN
    output logic [15:0]                 frames_sent,
`endif
    output logic                        idle
);

    localparam int GW = $clog2(NUM_REQ);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     rr_next;
    logic [GW-1:0]     win_idx;
    logic              win_found;
    logic              grant_load;
    logic              frame_done;
    logic [BYTE_W-1:0] req_bytes [NUM_REQ];

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tx_en)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
        end
    end

    // First pending requester at or after rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        logic [GW:0] cand;
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (GW+1)'(i);
            if (cand >= (GW+1)'(NUM_REQ)) begin
                cand = cand - (GW+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[GW-1:0];
            end
        end
    end

    assign rr_next = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        uart_start = 1'b0;
        req_ready  = '0;
        grant_load = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && !uart_busy) begin
                    state_nxt  = LAUNCH;
                    grant_load = 1'b1;
                end
            end
            LAUNCH: begin
                uart_start          = 1'b1;
                req_ready[grant_id] = 1'b1;
                state_nxt           = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            uart_data <= '0;
        end else begin
            state <= state_nxt;
            if (grant_load) begin
                grant_id  <= win_idx;
                uart_data <= req_bytes[win_idx];
            end
            if (frame_done) begin
                rr_ptr <= rr_next;
            end
        end
    end

`ifdef UART_TX_ARB_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_sent <= '0;
        end else if (frame_done) begin
            frames_sent <= frames_sent + 16'd1;
        end
    end
`endif

    assign idle = (state == IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural uart_tx model.
// Frame counter checks are compiled in when UART_TX_ARB_CNT_EN is defined.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int BAUD_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_en;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        uart_busy;
    logic [1:0]  grant_id;
    logic        idle;
`ifdef UART_TX_ARB_CNT_EN
    logic [15:0] frames_sent;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .BAUD_DIV (BAUD_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_en      (tx_en),
        .uart_start (uart_start),
        .uart_data  (uart_data),
        .uart_busy  (uart_busy),
        .grant_id   (grant_id),
`ifdef UART_TX_ARB_CNT_EN
        .frames_sent(frames_sent),
`endif
        .idle       (idle)
    );

    // Behavioural uart_tx: start bit, 8 data bits LSB first, stop bit, one per tx_en.
    logic       model_en;
    logic       model_clr;
    logic       model_busy;
    logic       man_busy;
    logic [9:0] sh;
    logic [9:0] tx_word;
    int         bits_left;

    assign uart_busy = model_busy | man_busy;

    always @(posedge clk) begin
        if (model_clr) begin
            model_busy <= 1'b0;
            bits_left  <= 0;
            tx_word    <= '0;
            sh         <= '0;
        end else if (model_en && uart_start && !model_busy) begin
            sh         <= {1'b1, uart_data, 1'b0};
            bits_left  <= 10;
            model_busy <= 1'b1;
        end else if (model_busy && tx_en) begin
            tx_word   <= {sh[0], tx_word[9:1]};
            sh        <= sh >> 1;
            bits_left <= bits_left - 1;
            if (bits_left == 1) begin
                model_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch log and ack sanity, sampled on the falling edge.
    logic [1:0] grant_log [$];
    logic [7:0] data_log  [$];

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (uart_start) begin
                grant_log.push_back(grant_id);
                data_log.push_back(uart_data);
                check("ack_onehot", 32'($countones(req_ready)), 1);
            end else if (req_ready !== 4'b0000) begin
                check("ack_without_start", {28'd0, req_ready}, 0);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        model_clr = 1'b1;
        man_busy  = 1'b0;
        step(2);
        rst       = 1'b0;
        model_clr = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n = 0;
        while (!uart_start && n < budget) begin
            step(1);
            n++;
        end
        check({tag, "_start"}, {31'd0, uart_start}, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!idle && n < budget) begin
            step(1);
            n++;
        end
        check({tag, "_idle"}, {31'd0, idle}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int        exp_gnt  [5];
        logic [7:0] exp_byte [4];
        logic      early;
        int        n;

        exp_gnt  = '{0, 1, 2, 3, 0};
        exp_byte = '{8'h10, 8'h21, 8'h32, 8'h43};
        model_en = 1'b0;
        req_data = '0;

        // Reset values, then the baud tick pattern for BAUD_DIV=4.
        do_reset();
        check("rst_idle",       {31'd0, idle},       1);
        check("rst_uart_start", {31'd0, uart_start}, 0);
        check("rst_req_ready",  {28'd0, req_ready},  0);
        check("rst_grant_id",   {30'd0, grant_id},   0);
        check("rst_uart_data",  {24'd0, uart_data},  0);
        for (int c = 0; c < 12; c++) begin
            check($sformatf("tx_en_c%0d", c), {31'd0, tx_en}, (c % 4 == 3) ? 1 : 0);
            step(1);
        end

        // Single request from requester 2 and the serial frame it produces.
        do_reset();
        model_en        = 1'b1;
        req_data        = '0;
        req_data[23:16] = 8'hA5;
        req_valid       = 4'b0100;
        step(1);
        check("s1_uart_start", {31'd0, uart_start}, 1);
        check("s1_req_ready",  {28'd0, req_ready},  32'h4);
        check("s1_uart_data",  {24'd0, uart_data},  32'hA5);
        check("s1_grant_id",   {30'd0, grant_id},   2);
        req_valid = '0;
        wait_idle("s1", 200);
        check("s1_frame_bits", {22'd0, tx_word}, 32'h34A);

        // All four requesters held valid: rotation 0,1,2,3,0.
        do_reset();
        grant_log.delete();
        data_log.delete();
        req_data  = 32'h4332_2110;
        req_valid = 4'b1111;
        n = 0;
        while (grant_log.size() < 5 && n < 2000) begin
            step(1);
            n++;
        end
        req_valid = '0;
        check("rr_grant_count", grant_log.size(), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            check($sformatf("rr_grant_%0d", k), {30'd0, grant_log[k]}, exp_gnt[k]);
            check($sformatf("rr_data_%0d", k), {24'd0, data_log[k]}, {24'd0, exp_byte[exp_gnt[k]]});
        end
        wait_idle("rr", 200);

        // Request raised mid-frame waits for busy to fall; 2-cycle minimum gap.
        do_reset();
        req_data[31:24] = 8'h3C;
        req_valid       = 4'b1000;
        wait_start("mf_first", 20);
        req_valid = '0;
        n = 0;
        while (!uart_busy && n < 50) begin
            step(1);
            n++;
        end
        step(2);
        req_data[15:8] = 8'h5A;
        req_valid      = 4'b0010;
        early = 1'b0;
        n = 0;
        while (uart_busy && n < 200) begin
            early = early | uart_start | (|req_ready);
            step(1);
            n++;
        end
        check("mf_no_ack_mid_frame", {31'd0, early}, 0);
        check("mf_gap_cycle0", {31'd0, uart_start}, 0);
        step(1);
        check("mf_gap_cycle1", {31'd0, uart_start}, 0);
        step(1);
        check("mf_uart_start", {31'd0, uart_start}, 1);
        check("mf_grant_id",   {30'd0, grant_id},   1);
        check("mf_req_ready",  {28'd0, req_ready},  32'h2);
        check("mf_uart_data",  {24'd0, uart_data},  32'h5A);
        req_valid = '0;
        wait_idle("mf", 200);

        // Reset during WAIT_DONE with busy still high: same requester re-granted later.
        do_reset();
        model_en        = 1'b0;
        req_data[23:16] = 8'h77;
        req_valid       = 4'b0100;
        wait_start("ra_first", 20);
        man_busy = 1'b1;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("ra_idle",      {31'd0, idle},      1);
        check("ra_grant_id",  {30'd0, grant_id},  0);
        check("ra_uart_data", {24'd0, uart_data}, 0);
        early = 1'b0;
        for (int k = 0; k < 6; k++) begin
            early = early | uart_start;
            step(1);
        end
        check("ra_no_start_while_busy", {31'd0, early}, 0);
        man_busy = 1'b0;
        wait_start("ra_regrant", 10);
        check("ra_regrant_id",    {30'd0, grant_id},  2);
        check("ra_regrant_data",  {24'd0, uart_data}, 32'h77);
        check("ra_regrant_ready", {28'd0, req_ready}, 32'h4);
        req_valid = '0;

`ifdef UART_TX_ARB_CNT_EN
        // Frame counter wrap from a preset of 0xFFFE.
        do_reset();
        model_en = 1'b1;
        check("cnt_reset", {16'd0, frames_sent}, 0);
        force dut.frames_sent = 16'hFFFE;
        #1;
        release dut.frames_sent;
        for (int k = 0; k < 3; k++) begin
            req_data[7:0] = 8'(k);
            req_valid     = 4'b0001;
            wait_start($sformatf("cnt_f%0d", k), 50);
            req_valid = '0;
            wait_idle($sformatf("cnt_f%0d", k), 200);
            check($sformatf("cnt_value_%0d", k), {16'd0, frames_sent}, 32'(16'(16'hFFFF + k)));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
